// File: rtl/vga_sync_if.sv
// vga_sync_if -- timing bundle produced by vga_sync_gen.
//   hc, vc       : pixel / line counters (11 bit)
//   vidon        : (hc,vc) is inside the visible area
//   hsync, vsync : active-low sync pulses
//   pix_tick     : one-clk pulse on each pixel advance
//   frame_start  : one-clk pulse after (hc,vc) wraps to (0,0)
// master = generator side, slave = consumer side.
interface vga_sync_if;
  logic [10:0] hc;
  logic [10:0] vc;
  logic        vidon;
  logic        hsync;
  logic        vsync;
  logic        pix_tick;
  logic        frame_start;

  modport master (output hc, vc, vidon, hsync, vsync, pix_tick, frame_start);
  modport slave  (input  hc, vc, vidon, hsync, vsync, pix_tick, frame_start);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA raster timing generator.
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   vga   : vga_sync_if.master carrying counters, blanking, syncs, ticks
// A clock divider produces pix_tick every CLK_DIV clocks. On each tick the
// pixel/line counters advance, and vidon/hsync/vsync are registered from the
// *next* counter values so they never lag the counters.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic   clk,
  input  logic   rst_n,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HT_M1 = 11'(H_TOTAL - 1);
  localparam logic [10:0] VT_M1 = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VE  = 11'(H_VIS);
  localparam logic [10:0] V_VE  = 11'(V_VIS);
  localparam logic [10:0] HS_B  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_E  = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_B  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_E  = 11'(V_VIS + V_FP + V_SYNC);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;
  logic [10:0]   hc, vc, hc_nxt, vc_nxt;
  logic          hc_wrap, vc_wrap;
  logic          vidon, hsync, vsync, fstart;

  // Gated by rst_n so that CLK_DIV=1 (div stuck at 0) still reads 0 in reset.
  assign tick = rst_n && (div == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             div <= '0;
    else if (div >= DIV_M1) div <= '0;
    else                    div <= div + DW'(1);
  end

  // >= rather than == keeps the counters bounded for any totals.
  assign hc_wrap = (hc >= HT_M1);
  assign vc_wrap = (vc >= VT_M1);
  assign hc_nxt  = hc_wrap ? 11'd0 : hc + 11'd1;
  assign vc_nxt  = !hc_wrap ? vc : (vc_wrap ? 11'd0 : vc + 11'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc     <= '0;
      vc     <= '0;
      vidon  <= 1'b0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      fstart <= 1'b0;
    end else begin
      fstart <= tick && hc_wrap && vc_wrap;
      if (tick) begin
        hc    <= hc_nxt;
        vc    <= vc_nxt;
        // decoded from the next values: zero skew against hc/vc
        vidon <= (hc_nxt < H_VE) && (vc_nxt < V_VE);
        hsync <= !((hc_nxt >= HS_B) && (hc_nxt < HS_E));
        vsync <= !((vc_nxt >= VS_B) && (vc_nxt < VS_E));
      end
    end
  end

  assign vga.hc          = hc;
  assign vga.vc          = vc;
  assign vga.vidon       = vidon;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.pix_tick    = tick;
  assign vga.frame_start = fstart;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen -- three generators (default VGA at /4, reduced raster at /1
// and /3) driven with random reset pulses. Every negedge each output is checked
// against a model that derives position from elapsed clocks since reset.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        vid;
    logic        hs;
    logic        vs;
    logic        pt;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  bit   ra = 1'b0, rb = 1'b0, rc = 1'b0;
  int   na, nb, nc;
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   lastb = -1, lastc = -1;

  always #5 clk = ~clk;

  vga_sync_if ifa();
  vga_sync_if ifb();
  vga_sync_if ifc();

  vga_sync_gen u_a (.clk(clk), .rst_n(ra), .vga(ifa));

  vga_sync_gen #(.CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                 .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1))
    u_b (.clk(clk), .rst_n(rb), .vga(ifb));

  vga_sync_gen #(.CLK_DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                 .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1))
    u_c (.clk(clk), .rst_n(rc), .vga(ifc));

  // clock edges seen since reset release
  always @(posedge clk or negedge ra) if (!ra) na <= 0; else na <= na + 1;
  always @(posedge clk or negedge rb) if (!rb) nb <= 0; else nb <= nb + 1;
  always @(posedge clk or negedge rc) if (!rc) nc <= 0; else nc <= nc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Position is simply (ticks so far) mod frame size; ticks = n / d.
  function automatic obs_t model(bit rn, int n, int d,
                                 int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    obs_t e;
    int ht, vt, t, p, h, v;
    e = '{hc: 11'd0, vc: 11'd0, vid: 1'b0, hs: 1'b1, vs: 1'b1, pt: 1'b0, fs: 1'b0};
    if (!rn) return e;
    e.pt = ((n + 1) % d == 0);
    t = n / d;
    if (t == 0) return e;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p = t % (ht * vt);
    h = p % ht;
    v = p / ht;
    e.hc  = 11'(h);
    e.vc  = 11'(v);
    e.vid = (h < hv) && (v < vv);
    e.hs  = !((h >= hv + hf) && (h < hv + hf + hsw));
    e.vs  = !((v >= vv + vf) && (v < vv + vf + vsw));
    e.fs  = (p == 0) && (n % d == 0);
    return e;
  endfunction

  task automatic cmp(input string nm, input obs_t o, input obs_t e);
    chk({nm, ".hc"},          32'(o.hc),  32'(e.hc));
    chk({nm, ".vc"},          32'(o.vc),  32'(e.vc));
    chk({nm, ".vidon"},       32'(o.vid), 32'(e.vid));
    chk({nm, ".hsync"},       32'(o.hs),  32'(e.hs));
    chk({nm, ".vsync"},       32'(o.vs),  32'(e.vs));
    chk({nm, ".pix_tick"},    32'(o.pt),  32'(e.pt));
    chk({nm, ".frame_start"}, 32'(o.fs),  32'(e.fs));
  endtask

  always @(negedge clk) begin
    obs_t oa, ob, oc;
    cyc++;
    oa = {ifa.hc, ifa.vc, ifa.vidon, ifa.hsync, ifa.vsync, ifa.pix_tick, ifa.frame_start};
    ob = {ifb.hc, ifb.vc, ifb.vidon, ifb.hsync, ifb.vsync, ifb.pix_tick, ifb.frame_start};
    oc = {ifc.hc, ifc.vc, ifc.vidon, ifc.hsync, ifc.vsync, ifc.pix_tick, ifc.frame_start};
    cmp("A", oa, model(ra, na, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    cmp("B", ob, model(rb, nb, 1, 8, 2, 2, 2, 4, 1, 1, 1));
    cmp("C", oc, model(rc, nc, 3, 8, 2, 2, 2, 4, 1, 1, 1));
    // frame period between consecutive pulses with no reset in between
    if (!rb) lastb = -1;
    else if (ob.fs) begin
      if (lastb >= 0) chk("B.frame_period", 32'(cyc - lastb), 32'd98);
      lastb = cyc;
    end
    if (!rc) lastc = -1;
    else if (oc.fs) begin
      if (lastc >= 0) chk("C.frame_period", 32'(cyc - lastc), 32'd294);
      lastc = cyc;
    end
  end

  initial begin
    obs_t ea;
    int ahold, bhold, chold;
    ahold = 0; bhold = 0; chold = 0;
    repeat (3) @(posedge clk);
    #2;
    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    for (int i = 0; i < 6800; i++) begin
      @(posedge clk);
      #2;
      // A: asynchronous reset mid-line (hc=700) on line 1, away from any edge
      ea = model(ra, na, 4, 640, 16, 96, 48, 480, 10, 2, 33);
      if (ra && ea.hc == 11'd700 && ea.vc == 11'd1) begin
        ra = 1'b0; ahold = 2;
      end else if (!ra) begin
        if (ahold == 0) ra = 1'b1; else ahold--;
      end
      // B: three clean frames first, then random reset pulses
      if (rb && i > 350 && $urandom_range(0, 199) == 0) begin
        rb = 1'b0; bhold = $urandom_range(0, 3);
      end else if (!rb) begin
        if (bhold == 0) rb = 1'b1; else bhold--;
      end
      // C: random reset pulses anywhere in the frame
      if (rc && i > 100 && $urandom_range(0, 399) == 0) begin
        rc = 1'b0; chold = $urandom_range(0, 3);
      end else if (!rc) begin
        if (chold == 0) rc = 1'b1; else chold--;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
